// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam int unsigned COL_W  = 2;
    localparam int unsigned ROW_W  = 2;
    localparam int unsigned CODE_W = COL_W + ROW_W;

    localparam logic [3:0] COL0 = 4'b0001;
    localparam logic [3:0] COL1 = 4'b0010;
    localparam logic [3:0] COL2 = 4'b0100;
    localparam logic [3:0] COL3 = 4'b1000;

    function automatic logic [3:0] col_drive(input logic [COL_W-1:0] idx);
        unique case (idx)
            2'd0: col_drive = COL0;
            2'd1: col_drive = COL1;
            2'd2: col_drive = COL2;
            2'd3: col_drive = COL3;
        endcase
    endfunction

    // Multi-row presses resolve to the lowest row index.
    function automatic logic [ROW_W-1:0] lowest_row(input logic [3:0] pattern);
        priority casez (pattern)
            4'b???1: lowest_row = 2'd0;
            4'b??10: lowest_row = 2'd1;
            4'b?100: lowest_row = 2'd2;
            default: lowest_row = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer bringing the asynchronous row sense into the clock domain.
module row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] row_s
);

    logic [3:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= '0;
            row_s <= '0;
        end else begin
            meta  <= row;
            row_s <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scanner, press/release debouncer and single-entry key output register
// with valid/ready handshake and overrun reporting.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DWELL      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [3:0]        row,
    output logic [3:0]        scan,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              overrun
);

    localparam logic [7:0] DWELL_LAST = 8'(SCAN_DWELL - 1);
    localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [3:0]       row_s;
    logic [3:0]       pattern;
    logic [COL_W-1:0] col;
    logic [7:0]       cnt;
    logic             col_adv;
    logic             load;
    logic             drop;

    row_sync u_row_sync (
        .clk   (CLK),
        .rst   (RST),
        .row   (row),
        .row_s (row_s)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= SCAN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        col_adv    = 1'b0;
        unique case (state)
            SCAN: begin
                if (cnt == DWELL_LAST) begin
                    if (row_s != '0) state_next = DEBOUNCE;
                    else             col_adv    = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_s != pattern) begin
                    state_next = SCAN;
                    col_adv    = 1'b1;
                end else if (cnt == DEB_LAST) begin
                    state_next = PRESSED;
                end
            end
            PRESSED: state_next = RELEASE;
            RELEASE: begin
                if (row_s == '0 && cnt == DEB_LAST) begin
                    state_next = SCAN;
                    col_adv    = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        scan = col_drive(col);
        load = (state == PRESSED) && (!key_valid || key_ready);
        drop = (state == PRESSED) && !load;
    end

    // One counter serves dwell, press debounce and release debounce; it
    // restarts on every state entry and on every column advance.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt     <= '0;
            col     <= '0;
            pattern <= '0;
        end else begin
            if (state_next != state || col_adv)       cnt <= '0;
            else if (state == RELEASE && row_s != '0) cnt <= '0;
            else                                      cnt <= cnt + 8'd1;
            if (col_adv) col <= col + 2'd1;
            if (state == SCAN && state_next == DEBOUNCE) pattern <= row_s;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= drop;
            if (load) begin
                key_code  <= {col, lowest_row(pattern)};
                key_valid <= 1'b1;
            end else if (key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: keypad matrix model, expected-code
// scoreboard popped on each handshake transfer, and per-scenario tasks.
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] scan;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       overrun;

    logic [3:0] key_rows [4];
    logic [3:0] exp_q [$];
    logic [3:0] exp_code;
    logic       kv_prev = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         valid_rises = 0;
    int         overrun_cnt = 0;

    keypad_scan_ctrl #(
        .SCAN_DWELL      (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .row       (row),
        .scan      (scan),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // A pressed key connects its column drive to its row sense.
    always_comb begin
        row = '0;
        for (int c = 0; c < 4; c++)
            if (scan[c]) row = row | key_rows[c];
    end

    always @(negedge clk) begin
        if (key_valid && !kv_prev) valid_rises++;
        kv_prev = key_valid;
        if (overrun) overrun_cnt++;
        if (!rst && key_valid && key_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL transfer_unexpected: key_code=%b, required no transfer", key_code);
            end else begin
                exp_code = exp_q.pop_front();
                if (key_code !== exp_code) begin
                    n_err++;
                    $display("FAIL transfer_code: key_code=%b, required %b", key_code, exp_code);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] want;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({scan, key_code, key_valid, overrun} !== {4'b0001, 4'b0000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: scan=%b code=%b valid=%b ovr=%b, required 0001 0000 0 0",
                     scan, key_code, key_valid, overrun);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            want = 4'b0001 << ((i / 4) % 4);
            n_cmp++;
            if (scan !== want || key_valid !== 1'b0) begin
                n_err++;
                $display("FAIL idle_sweep[%0d]: scan=%b valid=%b, required %b 0", i, scan, key_valid, want);
            end
        end
    endtask

    task automatic test_single_press();
        int  base;
        int  lat;
        bit  found;
        key_ready = 1'b1;
        step();
        key_rows[2] = 4'b0100;
        exp_q.push_back(4'b1010);
        base  = valid_rises;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            if (scan === 4'b0100) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL single_col2: scan=%b, required 0100 within 40 cycles", scan);
        end
        lat = 0;
        for (int t = 1; t <= 20 && lat == 0; t++) begin
            @(negedge clk);
            if (key_valid === 1'b1) lat = t;
        end
        n_cmp++;
        if (lat != 9) begin
            n_err++;
            $display("FAIL single_latency: key_valid after %0d cycles of column 2, required 9", lat);
        end
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_pulse: key_valid=%b, required 0", key_valid);
        end
        repeat (50) @(negedge clk);
        n_cmp++;
        if (valid_rises - base != 1) begin
            n_err++;
            $display("FAIL single_no_repeat: %0d codes, required 1", valid_rises - base);
        end
        step();
        key_rows[2] = 4'b0000;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (scan === 4'b1000) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL single_release_advance: scan=%b, required 1000 within 20 cycles", scan);
        end
    endtask

    task automatic test_bounce();
        int base;
        bit found;
        base = valid_rises;
        for (int p = 0; p < 10; p++) begin
            step();
            key_rows[1] = p[0] ? 4'b0000 : 4'b0010;
            @(posedge clk);
        end
        n_cmp++;
        if (valid_rises != base) begin
            n_err++;
            $display("FAIL bounce_quiet: %0d codes during bounce, required 0", valid_rises - base);
        end
        step();
        key_rows[1] = 4'b0010;
        exp_q.push_back(4'b0101);
        found = 1'b0;
        for (int t = 0; t < 80 && !found; t++) begin
            @(negedge clk);
            if (key_valid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL bounce_stable_code: key_valid=%b, required 1 within 80 cycles", key_valid);
        end
        repeat (40) @(negedge clk);
        n_cmp++;
        if (valid_rises - base != 1) begin
            n_err++;
            $display("FAIL bounce_single: %0d codes, required 1", valid_rises - base);
        end
        step();
        key_rows[1] = 4'b0000;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_overrun();
        int base_ov;
        bit found;
        key_ready = 1'b0;
        base_ov = overrun_cnt;
        step();
        key_rows[1] = 4'b0001;
        exp_q.push_back(4'b0100);
        found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            @(negedge clk);
            if (key_valid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL overrun_first_code: key_valid=%b, required 1 within 60 cycles", key_valid);
        end
        step();
        key_rows[1] = 4'b0000;
        repeat (12) @(negedge clk);
        step();
        key_rows[3] = 4'b1000;
        found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            @(negedge clk);
            if (overrun === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found || key_code !== 4'b0100 || key_valid !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_hold: seen=%0d code=%b valid=%b, required 1 0100 1",
                     found, key_code, key_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_width: overrun=%b, required 0", overrun);
        end
        step();
        key_rows[3] = 4'b0000;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (overrun_cnt - base_ov != 1 || key_valid !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_count: pulses=%0d valid=%b, required 1 1", overrun_cnt - base_ov, key_valid);
        end
        step();
        key_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_drain: key_valid=%b, required 0", key_valid);
        end
    endtask

    task automatic test_multi_row();
        bit found;
        key_ready = 1'b1;
        step();
        key_rows[0] = 4'b1001;
        exp_q.push_back(4'b0000);
        found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            @(negedge clk);
            if (key_valid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL multi_row_code: key_valid=%b, required 1 within 60 cycles", key_valid);
        end
        step();
        key_rows[0] = 4'b0000;
        repeat (15) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL multi_row_drained: %0d codes pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        key_ready = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            if (scan === 4'b1000) found = 1'b1;
        end
        step();
        key_rows[2] = 4'b0001;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            if (scan === 4'b0100) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL rst_col2: scan=%b, required 0100 within 40 cycles", scan);
        end
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({scan, key_code, key_valid, overrun} !== {4'b0001, 4'b0000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_debounce: scan=%b code=%b valid=%b ovr=%b, required 0001 0000 0 0",
                     scan, key_code, key_valid, overrun);
        end
        key_rows[2] = 4'b0000;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (scan !== ((i < 4) ? 4'b0001 : 4'b0010)) begin
                n_err++;
                $display("FAIL rst_restart[%0d]: scan=%b, required %b", i, scan,
                         (i < 4) ? 4'b0001 : 4'b0010);
            end
        end
        step();
        key_rows[2] = 4'b0001;
        exp_q.push_back(4'b1000);
        found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            @(negedge clk);
            if (key_valid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found || key_code !== exp_q[0]) begin
            n_err++;
            $display("FAIL rst_pending_code: valid=%0d code=%b, required 1 %b", found, key_code, exp_q[0]);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({scan, key_code, key_valid, overrun} !== {4'b0001, 4'b0000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_handshake: scan=%b code=%b valid=%b ovr=%b, required 0001 0000 0 0",
                     scan, key_code, key_valid, overrun);
        end
        exp_q.delete();
        key_rows[2] = 4'b0000;
        step();
        rst = 1'b0;
        key_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (scan !== 4'b0001 || key_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_second_restart: scan=%b valid=%b, required 0001 0", scan, key_valid);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || key_valid !== 1'b0) begin
            n_err++;
            $display("FAIL final_idle: pending=%0d valid=%b, required 0 0", exp_q.size(), key_valid);
        end
    endtask

    initial begin
        for (int c = 0; c < 4; c++) key_rows[c] = 4'b0000;
        test_reset();
        test_single_press();
        test_bounce();
        test_overrun();
        test_multi_row();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
